// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending controller.
//   - coin values in nickel (5c) units
//   - controller state encoding
//   - product price helper
package vm_pkg;

    localparam int NICKLE_V  = 1;
    localparam int DIME_V    = 2;
    localparam int QUARTER_V = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vm_state_e;

    // Price of product k in nickel units.
    function automatic int price(input int k, input int base, input int step);
        return base + k * step;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy change/refund serializer.
//   clk_i_tb, rst_ni_tb           : clock, async active-low reset
//   load_i, load_val_i            : start a payout of load_val_i nickel units
//   chg_nickle_o/dime_o/quarter_o : registered coin pulses, at most one per cycle
//   done_o                        : nothing left to pay after the coin now showing
// The first coin is registered on the load edge itself, so it is visible in
// the cycle right after the load.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk_i_tb,
    input  logic                rst_ni_tb,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] load_val_i,
    output logic                chg_nickle_o,
    output logic                chg_dime_o,
    output logic                chg_quarter_o,
    output logic                done_o
);

    logic [CREDIT_W-1:0] rem_q;
    logic [CREDIT_W-1:0] src;

    always_comb src = load_i ? load_val_i : rem_q;

    always_ff @(posedge clk_i_tb or negedge rst_ni_tb) begin
        if (!rst_ni_tb) begin
            rem_q         <= '0;
            chg_nickle_o  <= 1'b0;
            chg_dime_o    <= 1'b0;
            chg_quarter_o <= 1'b0;
        end else begin
            chg_nickle_o  <= 1'b0;
            chg_dime_o    <= 1'b0;
            chg_quarter_o <= 1'b0;
            if (src >= CREDIT_W'(QUARTER_V)) begin
                chg_quarter_o <= 1'b1;
                rem_q         <= src - CREDIT_W'(QUARTER_V);
            end else if (src >= CREDIT_W'(DIME_V)) begin
                chg_dime_o <= 1'b1;
                rem_q      <= src - CREDIT_W'(DIME_V);
            end else if (src != '0) begin
                chg_nickle_o <= 1'b1;
                rem_q        <= src - CREDIT_W'(NICKLE_V);
            end else begin
                rem_q <= '0;
            end
        end
    end

    assign done_o = (rem_q == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit accumulation, product selection,
// greedy change / refund via change_dispenser. All outputs are registered.
//   nickle_i/dime_i/quarter_i : coin pulses
//   sel_valid_i, sel_id_i     : selection request
//   cancel_i                  : refund request
//   credit_o                  : credit in nickel units
//   vend_valid_o, vend_id_o   : one-cycle vend pulse and product index
//   chg_*_o                   : change coin pulses
//   reject_o, deny_o          : refused coin / refused selection pulses
//   busy_o                    : high while vending or paying out
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int CREDIT_W     = 8,
    parameter int PRICE_BASE   = 4,
    parameter int PRICE_STEP   = 1,
    parameter int MAX_CREDIT   = 40,
    localparam int ID_W        = $clog2(NUM_PRODUCTS)
) (
    input  logic                clk_i_tb,
    input  logic                rst_ni_tb,
    input  logic                nickle_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                sel_valid_i,
    input  logic [ID_W-1:0]     sel_id_i,
    input  logic                cancel_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                vend_valid_o,
    output logic [ID_W-1:0]     vend_id_o,
    output logic                chg_nickle_o,
    output logic                chg_dime_o,
    output logic                chg_quarter_o,
    output logic                reject_o,
    output logic                deny_o,
    output logic                busy_o
);

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] rem_q, rem_d;
    logic                vend_valid_d, reject_d, deny_d, busy_d;
    logic [ID_W-1:0]     vend_id_d;
    logic                disp_load;
    logic [CREDIT_W-1:0] disp_val;
    logic                disp_done;
    logic [1:0]          coin_cnt;
    logic                any_coin;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   credit_sum;
    int                  sel_price;

    always_comb begin
        coin_cnt = {1'b0, nickle_i} + {1'b0, dime_i} + {1'b0, quarter_i};
        any_coin = nickle_i | dime_i | quarter_i;
        if (quarter_i)   coin_val = CREDIT_W'(QUARTER_V);
        else if (dime_i) coin_val = CREDIT_W'(DIME_V);
        else             coin_val = CREDIT_W'(NICKLE_V);
        // One extra bit so the cap check cannot wrap.
        credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
        sel_price  = price(int'(sel_id_i), PRICE_BASE, PRICE_STEP);
    end

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        rem_d        = rem_q;
        vend_valid_d = 1'b0;
        vend_id_d    = '0;
        reject_d     = 1'b0;
        deny_d       = 1'b0;
        disp_load    = 1'b0;
        disp_val     = rem_q;
        unique case (state_q)
            IDLE, CREDIT: begin
                if (cancel_i) begin
                    reject_d = any_coin;
                    if (credit_q != '0) begin
                        disp_load = 1'b1;
                        disp_val  = credit_q;
                        credit_d  = '0;
                        state_d   = CHANGE;
                    end
                end else if (sel_valid_i) begin
                    reject_d = any_coin;
                    if (int'(sel_id_i) < NUM_PRODUCTS && int'(credit_q) >= sel_price) begin
                        rem_d        = credit_q - CREDIT_W'(sel_price);
                        credit_d     = '0;
                        vend_valid_d = 1'b1;
                        vend_id_d    = sel_id_i;
                        state_d      = VEND;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (coin_cnt == 2'd1) begin
                    if (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (coin_cnt > 2'd1) begin
                    reject_d = 1'b1;
                end
            end
            VEND: begin
                reject_d = any_coin;
                deny_d   = sel_valid_i;
                rem_d    = '0;
                if (rem_q != '0) begin
                    disp_load = 1'b1;
                    disp_val  = rem_q;
                    state_d   = CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                reject_d = any_coin;
                deny_d   = sel_valid_i;
                // disp_done here means the coin on the outputs is the last one.
                if (disp_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk_i_tb or negedge rst_ni_tb) begin
        if (!rst_ni_tb) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            rem_q        <= '0;
            vend_valid_o <= 1'b0;
            vend_id_o    <= '0;
            reject_o     <= 1'b0;
            deny_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            rem_q        <= rem_d;
            vend_valid_o <= vend_valid_d;
            vend_id_o    <= vend_id_d;
            reject_o     <= reject_d;
            deny_o       <= deny_d;
            busy_o       <= busy_d;
        end
    end

    assign credit_o = credit_q;

    change_dispenser #(
        .CREDIT_W(CREDIT_W)
    ) u_change_dispenser (
        .clk_i_tb      (clk_i_tb),
        .rst_ni_tb     (rst_ni_tb),
        .load_i        (disp_load),
        .load_val_i    (disp_val),
        .chg_nickle_o  (chg_nickle_o),
        .chg_dime_o    (chg_dime_o),
        .chg_quarter_o (chg_quarter_o),
        .done_o        (disp_done)
    );

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi with default parameters
// (prices 4,5,6,7 nickels, cap 40).
module tb_vending_machine_multi;

    logic       clk_i_tb = 1'b0;
    logic       rst_ni_tb;
    logic       nickle_i, dime_i, quarter_i;
    logic       sel_valid_i, cancel_i;
    logic [1:0] sel_id_i;
    logic [7:0] credit_o;
    logic       vend_valid_o;
    logic [1:0] vend_id_o;
    logic       chg_nickle_o, chg_dime_o, chg_quarter_o;
    logic       reject_o, deny_o, busy_o;

    int total = 0;
    int bad   = 0;

    vending_machine_multi dut (
        .clk_i_tb      (clk_i_tb),
        .rst_ni_tb     (rst_ni_tb),
        .nickle_i      (nickle_i),
        .dime_i        (dime_i),
        .quarter_i     (quarter_i),
        .sel_valid_i   (sel_valid_i),
        .sel_id_i      (sel_id_i),
        .cancel_i      (cancel_i),
        .credit_o      (credit_o),
        .vend_valid_o  (vend_valid_o),
        .vend_id_o     (vend_id_o),
        .chg_nickle_o  (chg_nickle_o),
        .chg_dime_o    (chg_dime_o),
        .chg_quarter_o (chg_quarter_o),
        .reject_o      (reject_o),
        .deny_o        (deny_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i_tb = ~clk_i_tb;

    // {vend_valid, vend_id[1:0], quarter, dime, nickle, reject, deny, busy}
    logic [8:0] obs;
    assign obs = {vend_valid_o, vend_id_o, chg_quarter_o, chg_dime_o,
                  chg_nickle_o, reject_o, deny_o, busy_o};

    function automatic logic [8:0] ex(input bit v, input bit [1:0] id,
                                      input bit q, input bit d, input bit n,
                                      input bit rej, input bit den, input bit bsy);
        return {v, id, q, d, n, rej, den, bsy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i_tb);
        #1;
    endtask

    task automatic coin(input bit n, input bit d, input bit q);
        nickle_i = n; dime_i = d; quarter_i = q;
        step();
        nickle_i = 0; dime_i = 0; quarter_i = 0;
    endtask

    task automatic sel(input bit [1:0] id);
        sel_valid_i = 1; sel_id_i = id;
        step();
        sel_valid_i = 0; sel_id_i = 0;
    endtask

    task automatic cancel();
        cancel_i = 1;
        step();
        cancel_i = 0;
    endtask

    initial begin
        rst_ni_tb = 0;
        nickle_i = 0; dime_i = 0; quarter_i = 0;
        sel_valid_i = 0; sel_id_i = 0; cancel_i = 0;
        #12;
        chk("rst_obs", obs, 9'd0);
        chk("rst_credit", credit_o, 0);
        step();
        rst_ni_tb = 1;
        step();

        // Quarter, select 0 (price 4) -> vend, one nickel back
        coin(0, 0, 1);
        chk("t1_credit", credit_o, 5);
        sel(2'd0);
        chk("t1_vend", obs, ex(1, 0, 0, 0, 0, 0, 0, 1));
        chk("t1_credit0", credit_o, 0);
        step();
        chk("t1_nickle", obs, ex(0, 0, 0, 0, 1, 0, 0, 1));
        step();
        chk("t1_idle", obs, 9'd0);

        // Q,Q,D = 12, select 3 (price 7) -> one quarter back
        coin(0, 0, 1); coin(0, 0, 1); coin(0, 1, 0);
        chk("t2_credit", credit_o, 12);
        sel(2'd3);
        chk("t2_vend", obs, ex(1, 3, 0, 0, 0, 0, 0, 1));
        step();
        chk("t2_quarter", obs, ex(0, 0, 1, 0, 0, 0, 0, 1));
        step();
        chk("t2_idle", obs, 9'd0);
        // coin accepted in the first idle cycle
        coin(0, 1, 0);
        chk("t2_coin_after", credit_o, 2);
        cancel();
        chk("t2_refund", obs, ex(0, 0, 0, 1, 0, 0, 0, 1));
        step();
        chk("t2_idle2", obs, 9'd0);

        // Q,D,N = 8, cancel -> Q, D, N refund
        coin(0, 0, 1); coin(0, 1, 0); coin(1, 0, 0);
        chk("t3_credit", credit_o, 8);
        cancel();
        chk("t3_q", obs, ex(0, 0, 1, 0, 0, 0, 0, 1));
        chk("t3_credit0", credit_o, 0);
        step();
        chk("t3_d", obs, ex(0, 0, 0, 1, 0, 0, 0, 1));
        step();
        chk("t3_n", obs, ex(0, 0, 0, 0, 1, 0, 0, 1));
        step();
        chk("t3_idle", obs, 9'd0);

        // Nickel, select 0 denied; double coin rejected
        coin(1, 0, 0);
        sel(2'd0);
        chk("t4_deny", obs, ex(0, 0, 0, 0, 0, 0, 1, 0));
        chk("t4_credit", credit_o, 1);
        coin(1, 1, 0);
        chk("t4_reject", obs, ex(0, 0, 0, 0, 0, 1, 0, 0));
        chk("t4_credit2", credit_o, 1);
        step();
        chk("t4_pulse_end", obs, 9'd0);
        cancel();
        chk("t4_refund", obs, ex(0, 0, 0, 0, 1, 0, 0, 1));
        step();
        chk("t4_idle", obs, 9'd0);

        // Cap at 40, coin over cap rejected, coin during change rejected
        for (int i = 0; i < 8; i++) coin(0, 0, 1);
        chk("t5_credit40", credit_o, 40);
        coin(1, 0, 0);
        chk("t5_cap_reject", obs, ex(0, 0, 0, 0, 0, 1, 0, 0));
        chk("t5_credit_kept", credit_o, 40);
        cancel();
        chk("t5_q1", obs, ex(0, 0, 1, 0, 0, 0, 0, 1));
        coin(0, 1, 0);
        chk("t5_q2_rej", obs, ex(0, 0, 1, 0, 0, 1, 0, 1));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_qn", obs, ex(0, 0, 1, 0, 0, 0, 0, 1));
        end
        step();
        chk("t5_idle", obs, 9'd0);
        chk("t5_credit0", credit_o, 0);

        // Reset during change with coins pending
        coin(0, 0, 1); coin(0, 0, 1); coin(1, 0, 0);
        chk("t6_credit", credit_o, 11);
        cancel();
        chk("t6_q1", obs, ex(0, 0, 1, 0, 0, 0, 0, 1));
        rst_ni_tb = 0;
        #1;
        chk("t6_rst_obs", obs, 9'd0);
        chk("t6_rst_credit", credit_o, 0);
        step(); step();
        rst_ni_tb = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_quiet", obs, 9'd0);
        end
        coin(1, 0, 0);
        chk("t6_idle_coin", credit_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
